// File: rtl/cnn1d_pkg.sv
// Shared types and helpers for the cnn1d front-end blocks.
package cnn1d_pkg;

   typedef enum logic [2:0] {IDLE, STREAM, DRAIN, WAIT, REPORT} seq_state_t;

   // Samples needed so a valid-only conv feeds exactly pool_size outputs.
   function automatic int win_len(input int filter_size, input int pool_size);
      return pool_size + filter_size - 1;
   endfunction

endpackage

// File: rtl/cnn1d_skid_buffer.sv
// Two-entry ready/valid skid buffer: 1-cycle latency, full throughput,
// upstream ready comes straight from a flop.
module cnn1d_skid_buffer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  up_valid,
   output logic                  up_ready,
   input  logic [DATA_WIDTH-1:0] up_data,
   output logic                  dn_valid,
   input  logic                  dn_ready,
   output logic [DATA_WIDTH-1:0] dn_data,
   output logic                  empty
);

   logic                  skid_valid;
   logic [DATA_WIDTH-1:0] skid_data;
   logic                  up_fire;

   assign up_ready = !skid_valid;
   assign up_fire  = up_valid && up_ready;
   assign empty    = !dn_valid && !skid_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         dn_valid   <= 1'b0;
         dn_data    <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (!dn_valid || dn_ready) begin
         // Output slot frees up: the parked sample goes first to keep order.
         if (skid_valid) begin
            dn_valid   <= 1'b1;
            dn_data    <= skid_data;
            skid_valid <= 1'b0;
         end else begin
            dn_valid <= up_fire;
            if (up_fire)
               dn_data <= up_data;
         end
      end else if (up_fire) begin
         skid_valid <= 1'b1;
         skid_data  <= up_data;
      end
   end

endmodule

// File: rtl/cnn1d_frame_sequencer.sv
// Cuts the raw sample stream into WINDOW_LEN windows for cnn1d, then waits
// for the classification (or a timeout) and reports it with a frame ID.
module cnn1d_frame_sequencer
   import cnn1d_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int FILTER_SIZE    = 5,
   parameter int POOL_SIZE      = 256,
   parameter int NUM_NEURONS    = 2,
   parameter int FRAME_ID_WIDTH = 8,
   parameter int TIMEOUT_CYCLES = 4096,
   localparam int CLASS_WIDTH   = ($clog2(NUM_NEURONS) > 1) ? $clog2(NUM_NEURONS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      smp_valid_in,
   output logic                      smp_ready_in,
   input  logic [DATA_WIDTH-1:0]     smp_data_in,
   output logic                      cnn_valid_in,
   input  logic                      cnn_ready_in,
   output logic [DATA_WIDTH-1:0]     cnn_data_in,
   input  logic                      cnn_result_valid,
   output logic                      cnn_ready_out,
   input  logic [CLASS_WIDTH-1:0]    cnn_condition,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [CLASS_WIDTH-1:0]    res_class,
   output logic [FRAME_ID_WIDTH-1:0] res_frame_id,
   output logic                      res_timeout,
   output logic                      busy
);

   localparam int WINDOW_LEN = win_len(FILTER_SIZE, POOL_SIZE);
   localparam int IN_W       = $clog2(WINDOW_LEN + 1);
   localparam int TO_W       = $clog2(TIMEOUT_CYCLES);

   seq_state_t      state;
   logic [IN_W-1:0] in_cnt;
   logic [TO_W-1:0] to_cnt;
   logic            accept_q;
   logic            skid_up_ready;
   logic            skid_empty;
   logic            in_fire;

   // Both terms are flops, so upstream ready never sees cnn_ready_in.
   assign smp_ready_in = accept_q && skid_up_ready;
   assign in_fire      = smp_valid_in && smp_ready_in;
   assign busy         = (state != IDLE);

   cnn1d_skid_buffer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .up_valid (smp_valid_in && accept_q),
      .up_ready (skid_up_ready),
      .up_data  (smp_data_in),
      .dn_valid (cnn_valid_in),
      .dn_ready (cnn_ready_in),
      .dn_data  (cnn_data_in),
      .empty    (skid_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         in_cnt        <= '0;
         to_cnt        <= '0;
         accept_q      <= 1'b0;
         cnn_ready_out <= 1'b0;
         res_valid     <= 1'b0;
         res_class     <= '0;
         res_frame_id  <= '0;
         res_timeout   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enable) begin
                  state    <= STREAM;
                  in_cnt   <= '0;
                  accept_q <= 1'b1;
               end
            end
            STREAM: begin
               if (in_fire) begin
                  in_cnt <= in_cnt + IN_W'(1);
                  if (in_cnt == IN_W'(WINDOW_LEN - 1)) begin
                     accept_q <= 1'b0;
                     state    <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (skid_empty) begin
                  state         <= WAIT;
                  to_cnt        <= '0;
                  cnn_ready_out <= 1'b1;
               end
            end
            WAIT: begin
               to_cnt <= to_cnt + TO_W'(1);
               // A result arriving on the timeout cycle still wins.
               if (cnn_result_valid) begin
                  res_class     <= cnn_condition;
                  res_timeout   <= 1'b0;
                  res_valid     <= 1'b1;
                  cnn_ready_out <= 1'b0;
                  state         <= REPORT;
               end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  res_class     <= '0;
                  res_timeout   <= 1'b1;
                  res_valid     <= 1'b1;
                  cnn_ready_out <= 1'b0;
                  state         <= REPORT;
               end
            end
            REPORT: begin
               if (res_ready) begin
                  res_valid    <= 1'b0;
                  res_frame_id <= res_frame_id + FRAME_ID_WIDTH'(1);
                  if (enable) begin
                     state    <= STREAM;
                     in_cnt   <= '0;
                     accept_q <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/cnn1d_frame_sequencer.md
Name: cnn1d_frame_sequencer

Overview:
- Sits between the raw sample stream (ADC/file source) and cnn1d.
- Cuts the stream into inference windows of exactly WINDOW_LEN samples and feeds each window to cnn1d over ready/valid.
- Waits for the classification, then reports it with a frame ID and a timeout flag.
- Guarantees cnn1d never receives a partial or overlapping window.

Parameters:
- DATA_WIDTH, 32, sample width (Q-format, FRACTION bits, pass-through only).
- FILTER_SIZE, 5, conv kernel length.
- POOL_SIZE, 256, global-pool length.
- NUM_NEURONS, 2, classifier outputs.
- FRAME_ID_WIDTH, 8, frame counter width.
- TIMEOUT_CYCLES, 4096, max cycles allowed in WAIT.
- Derived localparam WINDOW_LEN = POOL_SIZE+FILTER_SIZE-1 (260).
- Derived localparam CLASS_WIDTH = max(1,$clog2(NUM_NEURONS)).

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; permits starting new windows.
- smp_valid_in  in  1  upstream sample valid.
- smp_ready_in  out  1  upstream sample ready.
- smp_data_in  in  DATA_WIDTH  upstream sample.
- cnn_valid_in  out  1  sample valid to cnn1d.
- cnn_ready_in  in  1  cnn1d ready.
- cnn_data_in  out  DATA_WIDTH  sample to cnn1d.
- cnn_result_valid  in  1  cnn1d classification valid.
- cnn_ready_out  out  1  sequencer can accept a result.
- cnn_condition  in  CLASS_WIDTH  cnn1d class index.
- res_valid  out  1  report valid.
- res_ready  in  1  report consumer ready.
- res_class  out  CLASS_WIDTH  captured class.
- res_frame_id  out  FRAME_ID_WIDTH  window number.
- res_timeout  out  1  set when the report was caused by a timeout.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; all valids/readies 0; res_class 0; res_frame_id 0; res_timeout 0; busy 0; counters 0; skid buffer empty.
- Reset mid-operation discards the buffered sample, the partial window and any pending report.
- Transfer rule: a transfer occurs on a rising edge with valid&&ready. Valid, once high, holds data stable until it transfers.
- Datapath: a 2-entry skid buffer sits between smp_* and cnn_*.
  - Latency 1 cycle.
  - Full throughput of 1 sample/cycle under continuous ready.
  - smp_ready_in is registered and never depends combinationally on cnn_ready_in.
- FSM IDLE:
  - smp_ready_in=0, cnn_ready_out=0.
  - If enable=1, go to STREAM; in_cnt=0.
- FSM STREAM:
  - Input accepted while in_cnt<WINDOW_LEN and the skid has space. Each input transfer increments in_cnt.
  - The transfer that makes in_cnt==WINDOW_LEN drops smp_ready_in the next cycle; go to DRAIN.
- FSM DRAIN:
  - smp_ready_in=0.
  - When the skid is empty (the last cnn transfer is done), go to WAIT. to_cnt=0.
- FSM WAIT:
  - cnn_ready_out=1; to_cnt increments each cycle.
  - On cnn_result_valid: capture cnn_condition into res_class, res_timeout=0, go to REPORT.
  - Else if to_cnt==TIMEOUT_CYCLES-1: res_class=0, res_timeout=1, go to REPORT.
  - If cnn_result_valid and the timeout coincide in the same cycle, the result wins (res_timeout=0).
- FSM REPORT:
  - res_valid=1, cnn_ready_out=0; res_* held stable.
  - On res_ready: res_frame_id increments (wraps 2^FRAME_ID_WIDTH-1 → 0).
  - Next state is STREAM if enable=1 (in_cnt=0), else IDLE.
- enable deasserted mid-window: the current window completes through REPORT, then IDLE. enable is sampled only in IDLE and on REPORT exit.
- Stray result: a cnn_result_valid outside WAIT is ignored; cnn_ready_out=0 there.
- Arithmetic: counters are unsigned. in_cnt has $clog2(WINDOW_LEN+1) bits; to_cnt has $clog2(TIMEOUT_CYCLES) bits. Sample data is never modified.

Decomposition:
- cnn1d_pkg holds:
  - typedef enum logic [2:0] seq_state_t {IDLE, STREAM, DRAIN, WAIT, REPORT};
  - function win_len(FILTER_SIZE, POOL_SIZE).
- Sub-module cnn1d_skid_buffer (parameter DATA_WIDTH; 2 entries, ready/valid both sides) is reused later by other pipeline stages.
- The FSM and counters stay in cnn1d_frame_sequencer.

Test Plan:
- Continuous stream, enable=1, cnn_ready_in=1; cnn result class 1 returned 10 cycles after the last sample → exactly 260 cnn transfers, samples bit-identical and in order; res_valid with res_class=1, res_frame_id=0, res_timeout=0; the next window starts, and its report carries res_frame_id=1.
- Random cnn_ready_in (50%) and smp_valid_in (50%) over 3 windows → no sample lost or duplicated; 780 transfers total; cnn_valid_in never asserted in WAIT/REPORT.
- cnn1d never returns a result → res_valid after 4096 WAIT cycles with res_timeout=1, res_class=0; busy=1 until res_ready.
- enable dropped at sample 100 → window still completes all 260 samples and its report; then IDLE, smp_ready_in=0, busy=0.
- res_ready held 0 for 50 cycles → res_* stable the whole time; no input accepted (smp_ready_in=0).
- rst asserted for 1 cycle at sample 150 of frame 3 → all outputs at reset values the next cycle; res_frame_id=0; the next window restarts at in_cnt=0.
